// File: rtl/race_state_controller_pkg.sv
// Shared race definitions: state codes seen by the physics engines and UI,
// winner codes, axis operation codes and the rectangle hit test.
package race_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTING   = 3'd1,
    COUNTDOWN = 3'd3,
    RACING    = 3'd4,
    PAUSE     = 3'd5,
    FINISH    = 3'd6
  } race_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_TIE  = 2'd3
  } winner_e;

  // Axis selector used by the physics engines for H/V movement operations.
  typedef enum logic [1:0] {
    HV_OP_NONE = 2'd0,
    HV_OP_H    = 2'd1,
    HV_OP_V    = 2'd2,
    HV_OP_HV   = 2'd3
  } hv_op_e;

  localparam int POS_W = 10;

  function automatic logic in_rect(
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] y,
    input logic [POS_W-1:0] x0,
    input logic [POS_W-1:0] x1,
    input logic [POS_W-1:0] y0,
    input logic [POS_W-1:0] y1
  );
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

endpackage

// File: rtl/race_state_controller_lap_tracker.sv
// Per-player lap counter: a checkpoint visit arms the player, the next finish
// crossing while armed counts one lap and disarms.
module lap_tracker
  import race_pkg::*;
#(
  parameter int LAPS   = 3,
  parameter int FIN_X0 = 150,
  parameter int FIN_X1 = 170,
  parameter int FIN_Y0 = 0,
  parameter int FIN_Y1 = 60,
  parameter int CHK_X0 = 150,
  parameter int CHK_X1 = 170,
  parameter int CHK_Y0 = 180,
  parameter int CHK_Y1 = 239
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  output logic [2:0]       laps,
  output logic             armed,
  output logic             in_finish
);

  logic [2:0] r_laps;
  logic       r_armed;
  logic       w_in_fin;
  logic       w_in_chk;

  assign w_in_fin = in_rect(pos_x, pos_y, POS_W'(FIN_X0), POS_W'(FIN_X1),
                            POS_W'(FIN_Y0), POS_W'(FIN_Y1));
  assign w_in_chk = in_rect(pos_x, pos_y, POS_W'(CHK_X0), POS_W'(CHK_X1),
                            POS_W'(CHK_Y0), POS_W'(CHK_Y1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_laps  <= 3'd0;
      r_armed <= 1'b0;
    end else if (enable) begin
      // Disarming on the counting edge keeps finish-line dwell to one lap.
      if (w_in_fin && r_armed) begin
        r_armed <= 1'b0;
        if (r_laps != 3'(LAPS)) r_laps <= r_laps + 3'd1;
      end else if (w_in_chk) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign laps      = r_laps;
  assign armed     = r_armed;
  assign in_finish = w_in_fin;

endmodule

// File: rtl/race_state_controller.sv
// Race sequencer: setup, 3-2-1 countdown, racing with pause, lap counting,
// winner decision and the HUD race-seconds timer.
module race_state_controller
  import race_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int LAPS          = 3,
  parameter int FIN_X0        = 150,
  parameter int FIN_X1        = 170,
  parameter int FIN_Y0        = 0,
  parameter int FIN_Y1        = 60,
  parameter int CHK_X0        = 150,
  parameter int CHK_X1        = 170,
  parameter int CHK_Y0        = 180,
  parameter int CHK_Y1        = 239,
  parameter int TIME_MAX      = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pulse,
  input  logic        setting_confirm,
  input  logic        pause_pulse,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic [1:0]  countdown_val,
  output logic [2:0]  p1_laps,
  output logic [2:0]  p2_laps,
  output logic [1:0]  winner,
  output logic [9:0]  race_secs
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  race_state_e   r_state;
  logic [1:0]    r_cd;
  logic [TW-1:0] r_tick;
  logic [9:0]    r_secs;
  winner_e       r_winner;

  logic       w_tick_wrap;
  logic       w_lap_en;
  logic       w_lap_clr;
  logic [2:0] w_p1_laps;
  logic [2:0] w_p2_laps;
  logic       w_p1_armed;
  logic       w_p2_armed;
  logic       w_p1_in_fin;
  logic       w_p2_in_fin;
  logic       w_p1_done;
  logic       w_p2_done;

  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_lap_en    = (r_state == RACING);
  assign w_lap_clr   = ((r_state == SETTING) && setting_confirm) ||
                       ((r_state == FINISH) && start_pulse);

  // A player finishes on the edge its tracker counts the final lap.
  assign w_p1_done = w_lap_en && w_p1_in_fin && w_p1_armed && (w_p1_laps == 3'(LAPS - 1));
  assign w_p2_done = w_lap_en && w_p2_in_fin && w_p2_armed && (w_p2_laps == 3'(LAPS - 1));

  lap_tracker #(
    .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
    .CHK_X0(CHK_X0), .CHK_X1(CHK_X1), .CHK_Y0(CHK_Y0), .CHK_Y1(CHK_Y1)
  ) u_p1_lap (
    .clk(clk), .rst(rst), .enable(w_lap_en), .clear(w_lap_clr),
    .pos_x(p1_x), .pos_y(p1_y),
    .laps(w_p1_laps), .armed(w_p1_armed), .in_finish(w_p1_in_fin)
  );

  lap_tracker #(
    .LAPS(LAPS), .FIN_X0(FIN_X0), .FIN_X1(FIN_X1), .FIN_Y0(FIN_Y0), .FIN_Y1(FIN_Y1),
    .CHK_X0(CHK_X0), .CHK_X1(CHK_X1), .CHK_Y0(CHK_Y0), .CHK_Y1(CHK_Y1)
  ) u_p2_lap (
    .clk(clk), .rst(rst), .enable(w_lap_en), .clear(w_lap_clr),
    .pos_x(p2_x), .pos_y(p2_y),
    .laps(w_p2_laps), .armed(w_p2_armed), .in_finish(w_p2_in_fin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cd     <= 2'd0;
      r_tick   <= '0;
      r_secs   <= 10'd0;
      r_winner <= WIN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_pulse) r_state <= SETTING;
        end
        SETTING: begin
          if (setting_confirm) begin
            r_state  <= COUNTDOWN;
            r_cd     <= 2'd3;
            r_tick   <= '0;
            r_secs   <= 10'd0;
            r_winner <= WIN_NONE;
          end
        end
        COUNTDOWN: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_cd == 2'd1) begin
              r_state <= RACING;
              r_cd    <= 2'd0;
            end else begin
              r_cd <= r_cd - 2'd1;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        RACING: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            if (r_secs != 10'(TIME_MAX)) r_secs <= r_secs + 10'd1;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
          // Finishing outranks a pause request on the same edge.
          if (w_p1_done || w_p2_done) begin
            r_state <= FINISH;
            if (w_p1_done && w_p2_done) r_winner <= WIN_TIE;
            else if (w_p1_done)         r_winner <= WIN_P1;
            else                        r_winner <= WIN_P2;
          end else if (pause_pulse) begin
            r_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_pulse) r_state <= RACING;
        end
        FINISH: begin
          if (start_pulse) begin
            r_state  <= IDLE;
            r_tick   <= '0;
            r_secs   <= 10'd0;
            r_winner <= WIN_NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state         = r_state;
  assign countdown_val = r_cd;
  assign p1_laps       = w_p1_laps;
  assign p2_laps       = w_p2_laps;
  assign winner        = r_winner;
  assign race_secs     = r_secs;

endmodule

// File: tb/tb_race_state_controller.sv
// Bench for race_state_controller: directed race scenarios plus random traffic,
// scored every cycle against a cycle-count based reference model.
module tb_race_state_controller;

  localparam int T = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_pulse;
  logic       setting_confirm;
  logic       pause_pulse;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [2:0] state;
  logic [1:0] countdown_val;
  logic [2:0] p1_laps, p2_laps;
  logic [1:0] winner;
  logic [9:0] race_secs;

  always #5 clk = ~clk;

  race_state_controller #(.TICKS_PER_SEC(T), .LAPS(L)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse),
    .setting_confirm(setting_confirm), .pause_pulse(pause_pulse),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .state(state), .countdown_val(countdown_val),
    .p1_laps(p1_laps), .p2_laps(p2_laps),
    .winner(winner), .race_secs(race_secs)
  );

  logic [22:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: phase plus elapsed-cycle counters from which the
  // countdown value and race seconds are derived arithmetically.
  int m_phase, m_cd_cycles, m_race_cycles, m_winner;
  int m_laps[2];
  int m_armed[2];

  function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  function automatic logic [22:0] expected_outputs();
    int cv, secs;
    cv   = (m_phase == 3) ? 3 - m_cd_cycles / T : 0;
    secs = (m_race_cycles / T > 999) ? 999 : m_race_cycles / T;
    return {3'(m_phase), 2'(cv), 3'(m_laps[0]), 3'(m_laps[1]), 2'(m_winner), 10'(secs)};
  endfunction

  task automatic model_step();
    int px[2], py[2];
    bit done[2];
    px[0] = int'(p1_x); py[0] = int'(p1_y);
    px[1] = int'(p2_x); py[1] = int'(p2_y);
    if (rst) begin
      m_phase = 0; m_cd_cycles = 0; m_race_cycles = 0; m_winner = 0;
      m_laps = '{0, 0}; m_armed = '{0, 0};
      return;
    end
    case (m_phase)
      0: if (start_pulse) m_phase = 1;
      1: if (setting_confirm) begin
        m_phase = 3; m_cd_cycles = 0; m_race_cycles = 0; m_winner = 0;
        m_laps = '{0, 0}; m_armed = '{0, 0};
      end
      3: begin
        m_cd_cycles++;
        if (m_cd_cycles == 3 * T) m_phase = 4;
      end
      4: begin
        for (int p = 0; p < 2; p++) begin
          done[p] = 1'b0;
          if (in_box(px[p], py[p], 150, 170, 0, 60) && m_armed[p] == 1) begin
            m_armed[p] = 0;
            if (m_laps[p] < L) begin
              m_laps[p]++;
              done[p] = (m_laps[p] == L);
            end
          end else if (in_box(px[p], py[p], 150, 170, 180, 239)) begin
            m_armed[p] = 1;
          end
        end
        m_race_cycles++;
        if (done[0] || done[1]) begin
          m_phase  = 6;
          m_winner = (done[0] && done[1]) ? 3 : (done[0] ? 1 : 2);
        end else if (pause_pulse) begin
          m_phase = 5;
        end
      end
      5: if (pause_pulse) m_phase = 4;
      6: if (start_pulse) begin
        m_phase = 0; m_race_cycles = 0; m_winner = 0;
        m_laps = '{0, 0}; m_armed = '{0, 0};
      end
      default: m_phase = 0;
    endcase
  endtask

  // region: 1 checkpoint, 2 finish line, otherwise somewhere else (often just outside a box)
  task automatic pick_pos(input int region, output logic [9:0] x, output logic [9:0] y);
    int k;
    k = int'($urandom_range(0, 5));
    case (region)
      1: begin
        x = 10'($urandom_range(150, 170)); y = 10'($urandom_range(180, 239));
        if (k == 0) begin
          x = ($urandom_range(0, 1) == 1) ? 10'd150 : 10'd170;
          y = ($urandom_range(0, 1) == 1) ? 10'd180 : 10'd239;
        end
      end
      2: begin
        x = 10'($urandom_range(150, 170)); y = 10'($urandom_range(0, 60));
        if (k == 0) begin
          x = ($urandom_range(0, 1) == 1) ? 10'd150 : 10'd170;
          y = ($urandom_range(0, 1) == 1) ? 10'd0 : 10'd60;
        end
      end
      default: begin
        case (k)
          0: begin x = 10'd149; y = 10'($urandom_range(0, 239)); end
          1: begin x = 10'd171; y = 10'($urandom_range(0, 239)); end
          2: begin x = 10'($urandom_range(150, 170)); y = 10'd61; end
          3: begin x = 10'($urandom_range(150, 170)); y = 10'd179; end
          4: begin x = 10'($urandom_range(150, 170)); y = 10'($urandom_range(240, 1023)); end
          default: begin x = 10'($urandom_range(0, 140)); y = 10'($urandom_range(0, 479)); end
        endcase
      end
    endcase
  endtask

  // One clock of stimulus; the model's prediction for the coming edge is queued.
  task automatic step(input bit r, input bit st, input bit sc, input bit pp,
                      input int reg1, input int reg2);
    @(negedge clk);
    rst = r; start_pulse = st; setting_confirm = sc; pause_pulse = pp;
    pick_pos(reg1, p1_x, p1_y);
    pick_pos(reg2, p2_x, p2_y);
    model_step();
    exp_q.push_back(expected_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_phase(input int ph, input int max_cycles, input string nm);
    int k;
    k = 0;
    while (m_phase != ph && k < max_cycles) begin
      step(0, 0, 0, 0, 0, 0);
      k++;
    end
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("FAIL wait_%s: phase %0d after %0d cycles, required %0d", nm, m_phase, k, ph);
    end
  endtask

  task automatic new_race();
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0);
    wait_phase(4, 3 * T + 2, "racing");
  endtask

  // Monitor: every clock edge the DUT presents its outputs; pop and compare.
  initial begin
    logic [22:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {state, countdown_val, p1_laps, p2_laps, winner, race_secs};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc %0d: got st=%0d cd=%0d l1=%0d l2=%0d win=%0d secs=%0d, required st=%0d cd=%0d l1=%0d l2=%0d win=%0d secs=%0d",
                   cyc, got_v[22:20], got_v[19:18], got_v[17:15], got_v[14:12], got_v[11:10], got_v[9:0],
                   exp_v[22:20], exp_v[19:18], exp_v[17:15], exp_v[14:12], exp_v[11:10], exp_v[9:0]);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; start_pulse = 1'b0; setting_confirm = 1'b0; pause_pulse = 1'b0;
    p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
    m_phase = 0; m_cd_cycles = 0; m_race_cycles = 0; m_winner = 0;
    m_laps = '{0, 0}; m_armed = '{0, 0};

    // Reset, idle noise, start, confirm, full countdown with ignored pulses
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 2);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3 * T; i++) step(0, (i == 3), 0, (i == 6), 1, 1);
    wait_phase(4, 2, "countdown_end");

    // Checkpoint then finish dwell counts once; finish without checkpoint does not
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 2, 2);
    step(0, 1, 0, 0, 0, 2);
    step(0, 0, 0, 0, 2, 0);

    // Pause at 5 seconds; positions must not arm or count while paused
    k = 0;
    while (m_race_cycles / T < 5 && k < 100) begin step(0, 0, 0, 0, 0, 0); k++; end
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, (i == 4), 0, 0, (i < 10) ? 1 : 2, (i < 10) ? 1 : 2);
    step(0, 0, 0, 1, 0, 0);
    idle(T + 1);

    // P2 catches up, then both finish lap 2 on the same edge
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 2, 2);
    step(0, 0, 0, 1, 1, 1);
    idle(2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(2);

    // Race 2: P2 alone finishes
    new_race();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 2, 2);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 2);
    idle(3);
    step(0, 1, 0, 0, 0, 0);

    // Race 3: pause on P1's final-lap edge is dropped
    new_race();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 2, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    idle(2);

    // Reset mid-countdown and mid-racing (with P1 armed beforehand)
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    new_race();
    step(0, 0, 0, 0, 1, 1);
    idle(6);
    step(1, 0, 0, 0, 0, 0);
    new_race();
    step(0, 0, 0, 0, 2, 2);
    idle(2);

    // Random traffic across all phases
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 14) == 0),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_state_controller.md
Name: race_state_controller

Overview:
- Top-level game sequencer. Produces the 3-bit race `state` consumed by both per-player physics engines and by display/UI blocks.
- Runs the setup, countdown, racing, pause and finish phases.
- Counts laps per player from the engines' position outputs and declares a winner.
- Maintains a race-seconds timer for the HUD.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per countdown/timer second.
- LAPS, 3, laps required to finish (1..7).
- FIN_X0/FIN_X1/FIN_Y0/FIN_Y1, 150/170/0/60, finish-line rectangle (inclusive, map pixels).
- CHK_X0/CHK_X1/CHK_Y0/CHK_Y1, 150/170/180/239, checkpoint rectangle (inclusive).
- TIME_MAX, 999, race_secs saturation value.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- start_pulse  in  1  one-cycle start/restart request
- setting_confirm  in  1  one-cycle "settings done" request
- pause_pulse  in  1  one-cycle pause toggle
- p1_x, p1_y, p2_x, p2_y  in  10 each  player positions from the physics engines
- state  out  3  IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
- countdown_val  out  2  3/2/1 during COUNTDOWN, else 0
- p1_laps, p2_laps  out  3 each  completed laps
- winner  out  2  0 none, 1 P1, 2 P2, 3 tie
- race_secs  out  10  elapsed racing seconds

Behaviour:
- Reset values: state=IDLE, countdown_val=0, laps=0, winner=0, race_secs=0, tick counter=0, armed flags=0.
- All outputs are registered. A pulse sampled at edge N takes effect at edge N.
- IDLE: start_pulse -> SETTING.
- SETTING:
  - setting_confirm -> COUNTDOWN.
  - Same edge: countdown_val=3, tick=0, laps=0, winner=0, race_secs=0, armed=0.
- COUNTDOWN:
  - tick counts 0..TICKS_PER_SEC-1. At wrap, countdown_val decrements.
  - At wrap while countdown_val==1: go to RACING with countdown_val=0.
  - Entry to RACING therefore occurs exactly 3*TICKS_PER_SEC cycles after entering COUNTDOWN.
  - pause_pulse and start_pulse are ignored.
- RACING:
  - tick runs; at each wrap race_secs increments, saturating at TIME_MAX.
  - pause_pulse -> PAUSE.
  - start_pulse is ignored.
- PAUSE:
  - tick, race_secs, laps and armed flags all frozen.
  - pause_pulse -> RACING, with tick resuming from its frozen value.
  - start_pulse is ignored.
- FINISH:
  - All counters frozen; winner held.
  - start_pulse -> IDLE and clears laps, winner, race_secs and tick.
- Lap tracking (RACING only, per player):
  - armed sets when the position is inside the checkpoint rectangle.
  - When the position is inside the finish rectangle and armed=1: laps+1 and armed cleared, on the same edge.
  - Finish-region dwell never counts more than once per checkpoint visit.
  - Laps saturate at LAPS.
- Finish decision:
  - On the edge where either lap counter becomes LAPS: state=FINISH, winner=1 or 2.
  - Both reach LAPS on the same edge: winner=3.
- Priority in RACING: finish > pause. A pause_pulse on the finishing edge is dropped and the state goes to FINISH.
- Undefined state encodings (2, 7) return to IDLE on the next edge.
- rst mid-operation: all registers return to reset values on that edge, regardless of state.
- Range checks are unsigned, inclusive comparisons on 10-bit values.

Decomposition:
- Shared package `race_pkg` holds:
  - state codes IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH, shared with the physics engine;
  - winner codes;
  - H/V operation codes.
- Sub-module `lap_tracker` (one per player): position plus rectangle parameters in; `enable` and `clear` inputs; `laps` and `armed` outputs.

Test Plan:
1. TICKS_PER_SEC=4: rst; start_pulse; setting_confirm at cycle 10 -> state 1 then 3, countdown_val 3,2,1 changing every 4 cycles, state=4 at cycle 22 with countdown_val=0.
2. RACING, P1 path checkpoint(160,200) -> finish(160,30) for 5 cycles -> p1_laps=1, increments once only. Finish without a prior checkpoint visit -> no increment.
3. LAPS=2, P1 and P2 complete lap 2 on the same edge -> state=6, winner=3. Single P2 completion -> winner=2.
4. RACING with race_secs=5: pause_pulse -> state=5. Hold 20 cycles -> race_secs stays 5 and laps unchanged. pause_pulse -> state=4, and race_secs=6 one second later.
5. pause_pulse on the same edge as P1's final lap -> state=6 (not 5), winner=1. Then start_pulse -> state=0, laps/winner/race_secs=0.
6. rst asserted mid-COUNTDOWN and mid-RACING -> next edge all outputs at reset values. start_pulse during RACING and COUNTDOWN -> no state change.
